pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline. It sits beside the EX-stage forwarding unit.
- It detects the load-use hazards that forwarding cannot cover, flushes wrong-path instructions after a taken branch or jump resolved in EX, and holds the pipe for multi-cycle mul/div operations and data-memory wait states.
- It drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM, and keeps saturating stall and flush performance counters.

---
 rtl/pipeline_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles,
// taken-branch flushes, mul/div hold with watchdog, dmem wait freezes.
module pipeline_ctrl #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MD_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       d_rs1,
   input  logic [4:0]       d_rs2,
   input  logic             d_uses_rs1,
   input  logic             d_uses_rs2,
   input  logic             e_mem_read,
   input  logic [4:0]       e_dest_reg,
   input  logic             e_branch_taken,
   input  logic             e_md_op,
   input  logic             md_done,
   input  logic             m_mem_access,
   input  logic             dmem_ready,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic             if_id_flush,
   output logic             id_ex_write_en,
   output logic             id_ex_flush,
   output logic             ex_mem_write_en,
   output logic             ex_mem_flush,
   output logic             md_start,
   output logic             md_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned MD_CNT_W = $clog2(MD_TIMEOUT) + 1;
   localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MD_BUSY,
      ST_MD_DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic                done_q, done_d;
   logic                rel_q, rel_c;
   logic                err_set_c;
   logic                flush_evt_c;
   logic                mem_wait_c;
   logic                load_use_c;
   logic                md_hit_c;

   assign mem_wait_c = m_mem_access & ~dmem_ready;
   assign load_use_c = e_mem_read && (e_dest_reg != 5'd0) &&
                       ((d_uses_rs1 && (d_rs1 == e_dest_reg)) ||
                        (d_uses_rs2 && (d_rs2 == e_dest_reg)));

   // State register, watchdog counter, sticky error and saturating counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         md_cnt_q    <= '0;
         done_q      <= 1'b0;
         rel_q       <= 1'b0;
         md_error    <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         done_q   <= done_d;
         rel_q    <= rel_c;
         md_error <= md_error | err_set_c;
         if (!pc_write_en && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_W'(1);
         if (flush_evt_c && (flush_count != CNT_MAX))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

   // Next state and pipeline controls
   always_comb begin
      state_d         = state_q;
      md_cnt_d        = md_cnt_q;
      done_d          = done_q;
      rel_c           = 1'b0;
      err_set_c       = 1'b0;
      flush_evt_c     = 1'b0;
      md_hit_c        = 1'b0;
      pc_write_en     = 1'b1;
      if_id_write_en  = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_write_en  = 1'b1;
      id_ex_flush     = 1'b0;
      ex_mem_write_en = 1'b1;
      ex_mem_flush    = 1'b0;
      md_start        = 1'b0;

      if (reset) begin
         // A dmem wait freezes every latch regardless of state
         if (mem_wait_c) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
         end

         case (state_q)
            ST_RUN: begin
               if (mem_wait_c) begin
                  state_d = ST_RUN;
               end else if (e_md_op && !rel_q) begin
                  md_start       = 1'b1;
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_write_en = 1'b0;
                  ex_mem_flush   = 1'b1;
                  md_cnt_d       = '0;
                  state_d        = ST_MD_BUSY;
               end else if (e_branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  flush_evt_c = 1'b1;
               end else if (load_use_c) begin
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_flush    = 1'b1;
               end
            end

            ST_MD_BUSY: begin
               md_cnt_d  = md_cnt_q + MD_CNT_W'(1);
               err_set_c = !md_done && (md_cnt_q == MD_LAST);
               md_hit_c  = md_done || (md_cnt_q == MD_LAST);
               if (mem_wait_c) begin
                  if (md_hit_c) begin
                     done_d  = 1'b1;
                     state_d = ST_MD_DRAIN;
                  end
               end else if (md_hit_c) begin
                  rel_c   = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_write_en = 1'b0;
                  ex_mem_flush   = 1'b1;
               end
            end

            ST_MD_DRAIN: begin
               if (!mem_wait_c) begin
                  done_d  = 1'b0;
                  rel_c   = 1'b1;
                  state_d = ST_RUN;
               end
            end

            default: state_d = ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TIMEOUT = 8;
   localparam int          CMAX    = (1 << CNT_W) - 1;

   // Control vector order: pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_fl, ex_mem_we, ex_mem_fl, md_start
   localparam logic [7:0] C_NORMAL = 8'b1101_0100;
   localparam logic [7:0] C_FREEZE = 8'b0000_0000;
   localparam logic [7:0] C_START  = 8'b0000_0111;
   localparam logic [7:0] C_HOLD   = 8'b0000_0110;
   localparam logic [7:0] C_BRANCH = 8'b1111_1100;
   localparam logic [7:0] C_LDUSE  = 8'b0001_1100;

   logic clk;
   logic reset;
   logic [4:0] d_rs1, d_rs2, e_dest_reg;
   logic d_uses_rs1, d_uses_rs2, e_mem_read, e_branch_taken, e_md_op;
   logic md_done, m_mem_access, dmem_ready;
   logic pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush;
   logic ex_mem_write_en, ex_mem_flush, md_start, md_error;
   logic [CNT_W-1:0] stall_count, flush_count;

   int n_pass = 0;
   int n_total = 0;

   // Model of the pipeline's view: is a mul/div outstanding, has its result
   // arrived but is stuck behind a memory wait, and how long it has waited.
   bit m_md_waiting;
   bit m_md_result_stuck;
   int m_md_cycles;
   bit m_prev_release;
   bit m_err;
   int m_stalls;
   int m_flushes;

   pipeline_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
      .e_mem_read(e_mem_read), .e_dest_reg(e_dest_reg), .e_branch_taken(e_branch_taken),
      .e_md_op(e_md_op), .md_done(md_done), .m_mem_access(m_mem_access),
      .dmem_ready(dmem_ready),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
      .id_ex_write_en(id_ex_write_en), .id_ex_flush(id_ex_flush),
      .ex_mem_write_en(ex_mem_write_en), .ex_mem_flush(ex_mem_flush),
      .md_start(md_start), .md_error(md_error),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic idle();
      reset = 1'b1;
      d_rs1 = 5'd0; d_rs2 = 5'd0; d_uses_rs1 = 1'b0; d_uses_rs2 = 1'b0;
      e_mem_read = 1'b0; e_dest_reg = 5'd0; e_branch_taken = 1'b0; e_md_op = 1'b0;
      md_done = 1'b0; m_mem_access = 1'b0; dmem_ready = 1'b1;
   endtask

   // Check the current cycle against the model, advance the model, cross the edge
   task automatic tick();
      logic [7:0] e;
      bit mw, lu, rel, timed_out, finished;
      #4;
      e   = C_NORMAL;
      rel = 1'b0;
      mw  = m_mem_access && !dmem_ready;
      lu  = e_mem_read && (e_dest_reg != 0) &&
            ((d_uses_rs1 && d_rs1 == e_dest_reg) || (d_uses_rs2 && d_rs2 == e_dest_reg));
      if (!reset) begin
         e = C_NORMAL;
      end else if (m_md_result_stuck) begin
         if (mw) e = C_FREEZE;
         else begin e = C_NORMAL; rel = 1'b1; end
      end else if (m_md_waiting) begin
         timed_out = !md_done && (m_md_cycles == TIMEOUT - 1);
         finished  = md_done || timed_out;
         if (mw) e = C_FREEZE;
         else if (finished) begin e = C_NORMAL; rel = 1'b1; end
         else e = C_HOLD;
      end else if (mw) e = C_FREEZE;
      else if (e_md_op && !m_prev_release) e = C_START;
      else if (e_branch_taken) e = C_BRANCH;
      else if (lu) e = C_LDUSE;

      chk("controls", 32'({pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
                           id_ex_flush, ex_mem_write_en, ex_mem_flush, md_start}), 32'(e));
      chk("stall_count", 32'(stall_count), 32'(m_stalls));
      chk("flush_count", 32'(flush_count), 32'(m_flushes));
      chk("md_error", 32'(md_error), 32'(m_err));

      if (!reset) begin
         m_md_waiting = 0; m_md_result_stuck = 0; m_md_cycles = 0;
         m_prev_release = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (m_md_result_stuck) begin
            if (!mw) m_md_result_stuck = 0;
         end else if (m_md_waiting) begin
            timed_out = !md_done && (m_md_cycles == TIMEOUT - 1);
            if (timed_out) m_err = 1;
            m_md_cycles++;
            if (md_done || timed_out) begin
               m_md_waiting = 0;
               if (mw) m_md_result_stuck = 1;
            end
         end else if (e == C_START) begin
            m_md_waiting = 1;
            m_md_cycles = 0;
         end else if (e == C_BRANCH && m_flushes < CMAX) m_flushes++;
         if (!e[7] && m_stalls < CMAX) m_stalls++;
         m_prev_release = rel;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      @(posedge clk);
      #1;
      tick();
      tick();

      // Load-use on rs2, then the same pattern with a load to x0
      idle();
      e_mem_read = 1'b1; e_dest_reg = 5'd5; d_rs2 = 5'd5; d_uses_rs2 = 1'b1;
      tick();
      idle();
      tick();
      e_mem_read = 1'b1; e_dest_reg = 5'd0; d_rs1 = 5'd0; d_uses_rs1 = 1'b1;
      tick();

      // Taken branch masks a simultaneous load-use
      idle();
      e_mem_read = 1'b1; e_dest_reg = 5'd7; d_rs1 = 5'd7; d_uses_rs1 = 1'b1;
      e_branch_taken = 1'b1;
      tick();
      idle();
      tick();

      // mul with md_done four cycles after md_start
      e_md_op = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) tick();
      md_done = 1'b1;
      tick();
      idle();
      tick();

      // md_done during a three-cycle dmem wait, then drain
      e_md_op = 1'b1;
      tick();
      tick();
      m_mem_access = 1'b1; dmem_ready = 1'b0; md_done = 1'b1;
      tick();
      md_done = 1'b0;
      tick();
      tick();
      dmem_ready = 1'b1;
      tick();
      tick();
      idle();
      tick();

      // div without md_done: watchdog release, sticky error, then reset mid-busy
      e_md_op = 1'b1;
      for (int i = 0; i < TIMEOUT + 1; i++) tick();
      idle();
      tick();
      tick();
      e_md_op = 1'b1;
      tick();
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1; e_md_op = 1'b0; md_done = 1'b1;
      tick();
      idle();
      tick();

      // Randomized traffic over a small register set to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         reset          = ($urandom_range(0, 299) != 0);
         d_rs1          = 5'($urandom_range(0, 3));
         d_rs2          = 5'($urandom_range(0, 3));
         d_uses_rs1     = 1'($urandom_range(0, 1));
         d_uses_rs2     = 1'($urandom_range(0, 1));
         e_mem_read     = ($urandom_range(0, 2) == 0);
         e_dest_reg     = 5'($urandom_range(0, 3));
         e_branch_taken = ($urandom_range(0, 7) == 0);
         e_md_op        = ($urandom_range(0, 9) == 0);
         md_done        = ($urandom_range(0, 3) == 0);
         m_mem_access   = 1'($urandom_range(0, 1));
         dmem_ready     = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
